// File: rtl/mpx_wb_arbiter_if.sv
// Writeback arbiter bus: source handshakes, issue hazard check, RF write port.
// MPX_WB_BYPASS_EN adds the forwarding outputs.
interface mpx_wb_arbiter_if;
   logic [2:0]  src_valid_i;
   logic [14:0] src_rd_i;
   logic [95:0] src_value_i;
   logic [2:0]  src_accept_o;
   logic        issue_valid_i;
   logic [4:0]  issue_ra_i;
   logic [4:0]  issue_rb_i;
   logic [4:0]  issue_rd_i;
   logic        issue_stall_o;
   logic        flush_i;
   logic [4:0]  rd0_o;
   logic [31:0] rd0_value_o;
   logic [31:0] pending_o;
`ifdef MPX_WB_BYPASS_EN
   logic        ra_fwd_o;
   logic        rb_fwd_o;
   logic [31:0] fwd_value_o;
`endif

   modport slave (
      input  src_valid_i, src_rd_i, src_value_i,
      input  issue_valid_i, issue_ra_i, issue_rb_i,
      input  issue_rd_i, flush_i,
      output src_accept_o, issue_stall_o,
      output rd0_o, rd0_value_o, pending_o
`ifdef MPX_WB_BYPASS_EN
      , output ra_fwd_o, rb_fwd_o, fwd_value_o
`endif
   );

   modport master (
      output src_valid_i, src_rd_i, src_value_i,
      output issue_valid_i, issue_ra_i, issue_rb_i,
      output issue_rd_i, flush_i,
      input  src_accept_o, issue_stall_o,
      input  rd0_o, rd0_value_o, pending_o
`ifdef MPX_WB_BYPASS_EN
      , input ra_fwd_o, rb_fwd_o, fwd_value_o
`endif
   );
endinterface

// File: rtl/mpx_wb_arbiter.sv
// Round-robin writeback arbiter with a 32-entry pending-write scoreboard.
// Optional forwarding from the RF write port: define MPX_WB_BYPASS_EN.
module mpx_wb_arbiter #(
   parameter int SRC_W = 2
) (
   input logic            clk_i,
   input logic            rst_i,
   mpx_wb_arbiter_if.slave bus
);

   logic [SRC_W-1:0] rr_ptr;
   logic [31:0]      pending;
   logic [31:0]      pend_nxt;
   logic [31:0]      pend_eff;
   logic [4:0]       rd0;
   logic [31:0]      rd0_val;

   logic [4:0]       s_rd  [3];
   logic [31:0]      s_val [3];
   logic [2:0]       req;
   logic [2:0]       zacc;
   logic [SRC_W:0]   idx;
   logic             gnt_any;
   logic [SRC_W-1:0] gnt_idx;
   logic [2:0]       accept;
   logic             stall;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         s_rd[i]  = bus.src_rd_i[5*i +: 5];
         s_val[i] = bus.src_value_i[32*i +: 32];
         req[i]   = bus.src_valid_i[i] & (|s_rd[i]);
         zacc[i]  = bus.src_valid_i[i] & ~(|s_rd[i]);
      end
   end

   // search starts at rr_ptr and wraps modulo 3
   always_comb begin
      idx     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < 3; k++) begin
         idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
         if (idx >= (SRC_W+1)'(3))
            idx = idx - (SRC_W+1)'(3);
         if (!gnt_any && req[idx[SRC_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = idx[SRC_W-1:0];
         end
      end
   end

   always_comb begin
      accept = zacc;
      if (gnt_any)
         accept = accept | (3'b001 << gnt_idx);
   end

`ifdef MPX_WB_BYPASS_EN
   // the value being written this cycle is forwarded, so it cannot stall
   assign pend_eff = pending & ~(32'd1 << rd0);
`else
   assign pend_eff = pending;
`endif

   assign stall = bus.issue_valid_i &
                  (pend_eff[bus.issue_ra_i] |
                   pend_eff[bus.issue_rb_i] |
                   pend_eff[bus.issue_rd_i]);

   always_comb begin
      pend_nxt = pending;
      if (rd0 != 5'd0)
         pend_nxt[rd0] = 1'b0;
      if (bus.issue_valid_i && !stall && bus.issue_rd_i != 5'd0)
         pend_nxt[bus.issue_rd_i] = 1'b1;
      if (bus.flush_i)
         pend_nxt = '0;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr  <= '0;
         pending <= '0;
         rd0     <= '0;
         rd0_val <= '0;
      end else begin
         pending <= pend_nxt;
         if (gnt_any) begin
            rd0     <= s_rd[gnt_idx];
            rd0_val <= s_val[gnt_idx];
            rr_ptr  <= (gnt_idx == SRC_W'(2)) ? '0 : gnt_idx + 1'b1;
         end else begin
            rd0 <= '0;
         end
      end
   end

   assign bus.src_accept_o  = accept;
   assign bus.issue_stall_o = stall;
   assign bus.rd0_o         = rd0;
   assign bus.rd0_value_o   = rd0_val;
   assign bus.pending_o     = pending;

`ifdef MPX_WB_BYPASS_EN
   assign bus.ra_fwd_o    = (rd0 != 5'd0) && (rd0 == bus.issue_ra_i);
   assign bus.rb_fwd_o    = (rd0 != 5'd0) && (rd0 == bus.issue_rb_i);
   assign bus.fwd_value_o = rd0_val;
`endif

endmodule

// File: tb/tb_mpx_wb_arbiter.sv
// Scoreboard bench for mpx_wb_arbiter: expected writes queued at drive time.
// Honours MPX_WB_BYPASS_EN for stall/forward expectations.
module tb_mpx_wb_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
   } wb_t;
   wb_t sb[$];

   mpx_wb_arbiter_if bus();

   mpx_wb_arbiter #(.SRC_W(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

`ifdef MPX_WB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic src(int s, logic v, logic [4:0] rd, logic [31:0] val);
      bus.src_valid_i[s]        = v;
      bus.src_rd_i[5*s +: 5]    = rd;
      bus.src_value_i[32*s +: 32] = val;
   endtask

   task automatic push(logic [4:0] rd, logic [31:0] val);
      wb_t e;
      e.rd  = rd;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic pop_chk(string tag);
      wb_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_rd"}, 32'(bus.rd0_o), 32'(e.rd));
         chk({tag, "_val"}, bus.rd0_value_o, e.val);
      end
   endtask

   task automatic issue(logic v, logic [4:0] ra, logic [4:0] rb,
                        logic [4:0] rd);
      bus.issue_valid_i = v;
      bus.issue_ra_i    = ra;
      bus.issue_rb_i    = rb;
      bus.issue_rd_i    = rd;
   endtask

   int exp_gnt [3] = '{0, 1, 2};
   logic [4:0]  t_rd  [3] = '{5'd1, 5'd2, 5'd4};
   logic [31:0] t_val [3] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC4C4_0004};

   initial begin
      bus.src_valid_i = '0;
      bus.src_rd_i    = '0;
      bus.src_value_i = '0;
      bus.flush_i     = 1'b0;
      issue(1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      chk("rst_rd0", 32'(bus.rd0_o), 32'd0);
      chk("rst_val", bus.rd0_value_o, 32'd0);
      chk("rst_pend", bus.pending_o, 32'd0);
      chk("rst_acc", 32'(bus.src_accept_o), 32'd0);
      chk("rst_stall", 32'(bus.issue_stall_o), 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // single ALU write
      src(0, 1'b1, 5'd3, 32'hDEADBEEF);
      push(5'd3, 32'hDEADBEEF);
      #1;
      chk("one_acc", 32'(bus.src_accept_o), 32'b001);
      step();
      src(0, 1'b0, 5'd0, 32'd0);
      pop_chk("one_wb");
      step();
      chk("one_idle_rd0", 32'(bus.rd0_o), 32'd0);
      chk("one_hold_val", bus.rd0_value_o, 32'hDEADBEEF);

      // reset while rd0_o=5 with a pending bit
      src(0, 1'b1, 5'd5, 32'h0000_0555);
      issue(1'b1, 5'd0, 5'd0, 5'd6);
      push(5'd5, 32'h0000_0555);
      step();
      src(0, 1'b0, 5'd0, 32'd0);
      issue(1'b0, 5'd0, 5'd0, 5'd0);
      pop_chk("mid_wb");
      chk("mid_pend", bus.pending_o, 32'h40);
      rst = 1'b1;
      #1;
      chk("mid_rst_rd0", 32'(bus.rd0_o), 32'd0);
      chk("mid_rst_pend", bus.pending_o, 32'd0);
      step();
      rst = 1'b0;
      step();

      // three held requests from rr_ptr=0
      for (int i = 0; i < 3; i++) begin
         src(i, 1'b1, t_rd[i], t_val[i]);
         push(t_rd[i], t_val[i]);
      end
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("rr_acc%0d", c), 32'(bus.src_accept_o),
             32'(3'b001 << exp_gnt[c]));
         step();
         src(exp_gnt[c], 1'b0, 5'd0, 32'd0);
         pop_chk($sformatf("rr_wb%0d", c));
      end
      step();
      chk("rr_idle", 32'(bus.rd0_o), 32'd0);

      // RAW hazard on x7 resolved by an LSU write
      issue(1'b1, 5'd0, 5'd0, 5'd7);
      #1;
      chk("raw_nostall", 32'(bus.issue_stall_o), 32'd0);
      step();
      issue(1'b1, 5'd7, 5'd0, 5'd0);
      src(1, 1'b1, 5'd7, 32'h0000_0777);
      push(5'd7, 32'h0000_0777);
      #1;
      chk("raw_pend", bus.pending_o, 32'h80);
      chk("raw_stall", 32'(bus.issue_stall_o), 32'd1);
      chk("raw_acc", 32'(bus.src_accept_o), 32'b010);
      step();
      src(1, 1'b0, 5'd0, 32'd0);
      pop_chk("raw_wb");
      chk("raw_stall_wb", 32'(bus.issue_stall_o), BYP ? 32'd0 : 32'd1);
      chk("raw_pend_wb", bus.pending_o, 32'h80);
      step();
      chk("raw_pend_clr", bus.pending_o, 32'd0);
      chk("raw_stall_clr", 32'(bus.issue_stall_o), 32'd0);
      issue(1'b0, 5'd0, 5'd0, 5'd0);

      // rd=0 request accepted alongside a real grant; set beats clear
      src(0, 1'b1, 5'd9, 32'h0000_0099);
      src(2, 1'b1, 5'd0, 32'h0000_1234);
      push(5'd9, 32'h0000_0099);
      #1;
      chk("z_acc", 32'(bus.src_accept_o), 32'b101);
      step();
      src(0, 1'b0, 5'd0, 32'd0);
      src(2, 1'b0, 5'd0, 32'd0);
      pop_chk("z_wb");
      issue(1'b1, 5'd0, 5'd0, 5'd9);
      #1;
      chk("sw_nostall", 32'(bus.issue_stall_o), 32'd0);
      step();
      issue(1'b0, 5'd0, 5'd0, 5'd0);
      chk("sw_pend", bus.pending_o, 32'h200);
      chk("z_rd0", 32'(bus.rd0_o), 32'd0);
      chk("z_hold", bus.rd0_value_o, 32'h0000_0099);

      // build pending=0x86, then flush against a same-cycle set
      issue(1'b1, 5'd0, 5'd0, 5'd1);
      src(1, 1'b1, 5'd9, 32'h0000_009A);
      push(5'd9, 32'h0000_009A);
      #1;
      chk("b_acc", 32'(bus.src_accept_o), 32'b010);
      step();
      src(1, 1'b0, 5'd0, 32'd0);
      pop_chk("b_wb");
      issue(1'b1, 5'd0, 5'd0, 5'd2);
      #1;
      chk("b_pend1", bus.pending_o, 32'h202);
      step();
      issue(1'b1, 5'd0, 5'd0, 5'd7);
      #1;
      chk("b_pend2", bus.pending_o, 32'h006);
      step();
      issue(1'b0, 5'd0, 5'd0, 5'd0);
      chk("b_pend3", bus.pending_o, 32'h86);
      bus.flush_i = 1'b1;
      issue(1'b1, 5'd0, 5'd0, 5'd3);
      step();
      bus.flush_i = 1'b0;
      issue(1'b1, 5'd1, 5'd2, 5'd0);
      #1;
      chk("fl_pend", bus.pending_o, 32'd0);
      chk("fl_stall", 32'(bus.issue_stall_o), 32'd0);
      issue(1'b0, 5'd0, 5'd0, 5'd0);
      step();

      // operand x5 is being written while the reader issues
      issue(1'b1, 5'd0, 5'd0, 5'd5);
      step();
      issue(1'b0, 5'd0, 5'd0, 5'd0);
      chk("fw_pend", bus.pending_o, 32'h20);
      src(0, 1'b1, 5'd5, 32'h0000_0055);
      push(5'd5, 32'h0000_0055);
      step();
      src(0, 1'b0, 5'd0, 32'd0);
      pop_chk("fw_wb");
      issue(1'b1, 5'd5, 5'd0, 5'd0);
      #1;
      chk("fw_stall", 32'(bus.issue_stall_o), BYP ? 32'd0 : 32'd1);
`ifdef MPX_WB_BYPASS_EN
      chk("fw_ra", 32'(bus.ra_fwd_o), 32'd1);
      chk("fw_rb", 32'(bus.rb_fwd_o), 32'd0);
      chk("fw_val", bus.fwd_value_o, 32'h0000_0055);
`endif
      step();
      issue(1'b0, 5'd0, 5'd0, 5'd0);
      chk("fw_pend_clr", bus.pending_o, 32'd0);

      chk("sb_left", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mpx_wb_arbiter.md
Name: mpx_wb_arbiter

Overview:
- Arbitrates three writeback sources (ALU, load/store, mul/div) onto the single write port of the 2-read/1-write integer register file.
- Keeps a 32-entry pending-write scoreboard and stalls issue on RAW/WAW hazards.
- Sits between the execute units and the register file write port, beside the issue stage.

Parameters:
- SRC_W, 2, width of the round-robin pointer (fixed three sources, encodings 0..2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- src_valid_i  in  3  per-source writeback request (bit0 ALU, bit1 LSU, bit2 MULDIV)
- src_rd_i  in  15  per-source destination register, 5 bits per source
- src_value_i  in  96  per-source result, 32 bits per source
- src_accept_o  out  3  per-source accept; transfer when valid & accept
- issue_valid_i  in  1  issue stage presenting an instruction
- issue_ra_i  in  5  source A index
- issue_rb_i  in  5  source B index
- issue_rd_i  in  5  destination index (0 = none)
- issue_stall_o  out  1  hazard, instruction must not issue
- flush_i  in  1  pipeline flush, clears scoreboard
- rd0_o  out  5  register file write index (0 = no write)
- rd0_value_o  out  32  register file write data
- pending_o  out  32  scoreboard bit vector

Behaviour:
- Reset (async, rst_i=1): rd0_o=0, rd0_value_o=0, pending=0, rr_ptr=0. Outputs hold these values until the first edge after release. src_accept_o and issue_stall_o are combinational and follow the cleared state.
- rd==0 requests: accepted the same cycle regardless of arbitration. No write, no pointer change.
- Arbitration among valid sources with rd!=0: round-robin starting at rr_ptr. Exactly one grant per cycle. src_accept_o is 1 for the granted source only.
- rr_ptr after a grant = (granted+1) mod 3. Unchanged when nothing is granted.
- Output register: at the edge of a grant, rd0_o/rd0_value_o <= the granted rd/value. With no grant, rd0_o <= 0 and rd0_value_o holds.
- Write latency: one cycle from accept to rd0_o; the register file captures on the following edge.
- Throughput: one write per cycle. A non-granted source holds valid/rd/value stable until accepted.
- Scoreboard set: issue_valid_i & ~issue_stall_o & issue_rd_i!=0 sets pending[issue_rd_i] at the edge.
- Scoreboard clear: rd0_o!=0 clears pending[rd0_o] at the edge; this is the same edge the register file commits.
- Set and clear of the same index in one cycle: set wins.
- pending[0] is always 0.
- issue_stall_o = issue_valid_i & (pending[ra] | pending[rb] | pending[rd]). Index 0 never stalls.
- flush_i: pending <= 0 at the edge. Arbitration and the output register are unaffected; in-flight results still write. flush_i has priority over a same-cycle set.
- Reset mid-transfer: the transfer is lost, rd0_o=0 immediately, scoreboard cleared.

Optional Feature:
- MPX_WB_BYPASS_EN defined: adds outputs ra_fwd_o/rb_fwd_o (1) and fwd_value_o (32).
  - ra_fwd_o=1 when rd0_o!=0 & rd0_o==issue_ra_i; likewise for rb.
  - issue_stall_o ignores pending bits whose index equals rd0_o, since the value is forwarded.
- Not defined: no forwarding ports; stall strictly from pending bits.

Test Plan:
- Reset mid-write (rd0_o=5) -> rd0_o=0 asynchronously, pending_o=0, rr_ptr=0.
- Single source: ALU rd=3, value 0xDEADBEEF -> accept same cycle, rd0_o=3 / rd0_value_o=0xDEADBEEF next cycle, then rd0_o=0.
- All three valid (rd=1,2,4) held from rr_ptr=0 -> grants ALU, LSU, MULDIV on consecutive cycles; rd0_o sequence 1,2,4.
- Issue rd=7, then issue ra=7 -> stall asserted until the cycle after rd0_o=7; pending_o[7] goes 1 then 0.
- Same-cycle issue rd=9 while rd0_o=9 -> pending_o[9] stays 1. A request with src rd=0 -> accepted, rd0_o stays 0.
- flush_i with pending=0x00000086 -> pending_o=0 next cycle, issue_stall_o=0. With MPX_WB_BYPASS_EN, rd0_o=5 & issue_ra=5 -> ra_fwd_o=1, no stall.
